// File: rtl/mem_wr_arbiter.sv
// Round-robin arbiter funnelling three upstream AXI write ports onto one downstream
// write channel, with a single transaction outstanding at a time.
module mem_wr_arbiter #(
  parameter int NPORT = 3,
  parameter int IDW   = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NPORT-1:0]     s_awvalid,
  output logic [NPORT-1:0]     s_awready,
  input  logic [NPORT*IDW-1:0] s_awid,
  input  logic [NPORT*32-1:0]  s_awaddr,
  input  logic [NPORT*8-1:0]   s_awlen,
  input  logic [NPORT-1:0]     s_wvalid,
  output logic [NPORT-1:0]     s_wready,
  input  logic [NPORT-1:0]     s_wlast,
  input  logic [NPORT*32-1:0]  s_wdata,
  input  logic [NPORT*4-1:0]   s_wstrb,
  output logic [NPORT-1:0]     s_bvalid,
  input  logic [NPORT-1:0]     s_bready,
  output logic [IDW-1:0]       s_bid,
  output logic [1:0]           s_bresp,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [IDW+1:0]       m_awid,
  output logic [31:0]          m_awaddr,
  output logic [7:0]           m_awlen,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wstrb,
  output logic                 m_wlast,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  input  logic [IDW+1:0]       m_bid,
  input  logic [1:0]           m_bresp
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_grant, r_last_grant;
  logic           r_init;
  logic [IDW+1:0] r_awid;
  logic [31:0]    r_awaddr;
  logic [7:0]     r_awlen;

  logic [1:0]     w_grant, w_c0, w_c1, w_c2;
  logic           w_aw_fire, w_b_fire;
  logic [IDW-1:0] w_awid_a  [NPORT];
  logic [31:0]    w_awaddr_a[NPORT];
  logic [7:0]     w_awlen_a [NPORT];
  logic [31:0]    w_wdata_a [NPORT];
  logic [3:0]     w_wstrb_a [NPORT];

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'(NPORT - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      w_awid_a[p]   = s_awid[p*IDW +: IDW];
      w_awaddr_a[p] = s_awaddr[p*32 +: 32];
      w_awlen_a[p]  = s_awlen[p*8 +: 8];
      w_wdata_a[p]  = s_wdata[p*32 +: 32];
      w_wstrb_a[p]  = s_wstrb[p*4 +: 4];
    end
  end

  // Candidates in priority order, starting just after the last completed grant.
  assign w_c0 = next_port(r_last_grant);
  assign w_c1 = next_port(w_c0);
  assign w_c2 = next_port(w_c1);

  always_comb begin
    if (s_awvalid[w_c0])      w_grant = w_c0;
    else if (s_awvalid[w_c1]) w_grant = w_c1;
    else                      w_grant = w_c2;
  end

  assign m_awid   = r_awid;
  assign m_awaddr = r_awaddr;
  assign m_awlen  = r_awlen;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path infers a latch.
    w_state_nxt = r_state;
    w_aw_fire   = 1'b0;
    w_b_fire    = 1'b0;
    s_awready   = '0;
    s_wready    = '0;
    s_bvalid    = '0;
    s_bid       = '0;
    s_bresp     = '0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // No grant while reset is asserted or in the first cycle after it.
        if (aresetn && !r_init && (|s_awvalid)) begin
          w_aw_fire          = 1'b1;
          s_awready[w_grant] = 1'b1;
          w_state_nxt        = S_AW;
        end
      end
      S_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) w_state_nxt = S_W;
      end
      S_W: begin
        m_wvalid           = s_wvalid[r_grant];
        m_wdata            = w_wdata_a[r_grant];
        m_wstrb            = w_wstrb_a[r_grant];
        m_wlast            = s_wlast[r_grant];
        s_wready[r_grant]  = m_wready;
        if (s_wvalid[r_grant] && m_wready && s_wlast[r_grant]) w_state_nxt = S_B;
      end
      S_B: begin
        // Response routed by the registered grant; m_bid[IDW+1:IDW] is ignored.
        s_bvalid[r_grant] = m_bvalid;
        m_bready          = s_bready[r_grant];
        s_bid             = m_bid[IDW-1:0];
        s_bresp           = m_bresp;
        if (m_bvalid && s_bready[r_grant]) begin
          w_b_fire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: the captured AW fields are plain registers, so they are cleared here too.
      r_state      <= S_IDLE;
      r_init       <= 1'b1;
      r_last_grant <= 2'(NPORT - 1);
      r_grant      <= '0;
      r_awid       <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= 1'b0;
      if (w_aw_fire) begin
        r_grant  <= w_grant;
        r_awid   <= {w_grant, w_awid_a[w_grant]};
        r_awaddr <= w_awaddr_a[w_grant];
        r_awlen  <= w_awlen_a[w_grant];
      end
      if (w_b_fire) r_last_grant <= r_grant;
    end
  end

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Self-checking bench for mem_wr_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a round-robin reference model.
module tb_mem_wr_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [2:0]  s_awvalid, s_awready;
  logic [11:0] s_awid;
  logic [95:0] s_awaddr;
  logic [23:0] s_awlen;
  logic [2:0]  s_wvalid, s_wready, s_wlast;
  logic [95:0] s_wdata;
  logic [11:0] s_wstrb;
  logic [2:0]  s_bvalid, s_bready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        m_awvalid, m_awready;
  logic [5:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic [5:0]  m_bid;
  logic [1:0]  m_bresp;

  logic [3:0]  awid_p [3];
  logic [31:0] addr_p [3];
  logic [7:0]  len_p  [3];
  logic [31:0] wdata_p[3];
  logic [3:0]  wstrb_p[3];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] model_last;

  always #5 aclk = ~aclk;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      s_awid[p*4 +: 4]   = awid_p[p];
      s_awaddr[p*32 +: 32] = addr_p[p];
      s_awlen[p*8 +: 8]  = len_p[p];
      s_wdata[p*32 +: 32] = wdata_p[p];
      s_wstrb[p*4 +: 4]  = wstrb_p[p];
    end
  end

  mem_wr_arbiter #(.NPORT(3), .IDW(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
  );

  typedef struct {
    logic [1:0]  port;
    logic [3:0]  awid;
    logic [31:0] addr;
    logic [7:0]  len;
    int          nbeats;
    logic [1:0]  bresp;
    logic [5:0]  exp_awid;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Round-robin rule: first requester searching upward from last+1 mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = (int'(last) + k) % 3;
      if (mask[p]) return 2'(p);
    end
    return 2'd0;
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_wlast, m_bready}, '0);
    check({name, "_aw"}, {m_awid, m_awlen, m_awaddr}, '0);
    check({name, "_w"}, {m_wdata, m_wstrb}, '0);
    check({name, "_b"}, {s_bid, s_bresp}, '0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_awvalid = 3'b111; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    #1;
    check("rst_awready_gated", s_awready, 3'b000);
    repeat (2) cyc();
    check_all_zero("in_reset");
    aresetn = 1'b1;
    #1;
    check_all_zero("first_after_reset");
    s_awvalid = 3'b000;
    model_last = 2'd2;
  endtask

  // One full transaction; the other requesters in mask stay pending throughout.
  task automatic txn(input logic [2:0] mask, input logic [1:0] exp_g, input logic [5:0] exp_id,
                     input int nbeats, input int aw_stall, input bit wtoggle, input logic [1:0] bresp);
    logic [31:0] e_addr, base;
    logic [7:0]  e_len;
    int          t, beats, lasts;
    bit          done;
    s_awvalid = mask;
    #1;
    t = 0;
    while (s_awready == 3'b000 && t < 8) begin
      cyc();
      t++;
    end
    check("aw_grant", s_awready, 3'b001 << exp_g);
    e_addr = addr_p[exp_g];
    e_len  = len_p[exp_g];
    cyc();
    s_awvalid = mask & ~(3'b001 << exp_g);
    m_wready  = 1'b1;
    for (int i = 0; i <= aw_stall; i++) begin
      m_awready = (i == aw_stall);
      #1;
      check("aw_valid", m_awvalid, 1'b1);
      check("aw_fields", {m_awid, m_awlen, m_awaddr}, {exp_id, e_len, e_addr});
      check("aw_no_other_ready", {s_awready, s_wready}, '0);
      cyc();
    end
    m_awready = 1'b0;
    #1;
    check("aw_dropped", m_awvalid, 1'b0);

    base = $urandom; beats = 0; lasts = 0; done = 1'b0;
    for (int c = 0; c < 4 * nbeats + 8 && !done; c++) begin
      s_wvalid[exp_g] = 1'b1;
      wdata_p[exp_g]  = base + 32'(beats);
      wstrb_p[exp_g]  = base[3:0] ^ 4'(beats);
      s_wlast[exp_g]  = (beats == nbeats - 1);
      m_wready = wtoggle ? (c % 2 == 0) : 1'b1;
      #1;
      check("w_valid", m_wvalid, 1'b1);
      check("w_data", {m_wstrb, m_wdata}, {base[3:0] ^ 4'(beats), base + 32'(beats)});
      check("w_last", m_wlast, (beats == nbeats - 1));
      check("w_sready", s_wready, m_wready ? (3'b001 << exp_g) : 3'b000);
      if (m_wready && m_wvalid) begin
        if (m_wlast) lasts++;
        beats++;
        if (beats == nbeats) done = 1'b1;
      end
      cyc();
    end
    check("w_beat_count", beats, nbeats);
    check("w_last_count", lasts, 1);
    s_wvalid[exp_g] = 1'b0;
    s_wlast[exp_g]  = 1'b0;
    m_wready = 1'b1;

    m_bvalid = 1'b1;
    m_bid    = {2'($urandom_range(0, 3)), awid_p[exp_g]};
    m_bresp  = bresp;
    s_bready = ~(3'b001 << exp_g);
    #1;
    check("b_w_gated", {m_wvalid, s_wready}, '0);
    check("b_svalid", s_bvalid, 3'b001 << exp_g);
    check("b_id_resp", {s_bid, s_bresp}, {exp_id[3:0], bresp});
    check("b_mready_other", m_bready, 1'b0);
    s_bready = 3'b001 << exp_g;
    #1;
    check("b_mready", m_bready, 1'b1);
    cyc();
    m_bvalid = 1'b0; s_bready = '0; m_wready = 1'b0;
    #1;
    check("b_done", {s_bvalid, m_bready}, '0);
    model_last = exp_g;
  endtask

  vec_t       vecs[5];
  logic [1:0] order[6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] mask;
    logic [1:0] g;
    for (int p = 0; p < 3; p++) begin
      awid_p[p] = '0; addr_p[p] = '0; len_p[p] = '0; wdata_p[p] = '0; wstrb_p[p] = '0;
    end
    vecs[0] = '{2'd1, 4'h3, 32'h0000_0100, 8'd1, 2, 2'b00, 6'h13};
    vecs[1] = '{2'd0, 4'hA, 32'hDEAD_BEE0, 8'd0, 1, 2'b10, 6'h0A};
    vecs[2] = '{2'd2, 4'hF, 32'hFFFF_FFFC, 8'd3, 4, 2'b01, 6'h2F};
    vecs[3] = '{2'd1, 4'h0, 32'h0000_0000, 8'd2, 3, 2'b11, 6'h10};
    vecs[4] = '{2'd2, 4'h5, 32'h1234_5670, 8'd0, 1, 2'b00, 6'h25};
    order   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    do_reset();

    // Directed single-port vectors.
    for (int i = 0; i < 5; i++) begin
      awid_p[vecs[i].port] = vecs[i].awid;
      addr_p[vecs[i].port] = vecs[i].addr;
      len_p[vecs[i].port]  = vecs[i].len;
      txn(3'b001 << vecs[i].port, vecs[i].port, vecs[i].exp_awid, vecs[i].nbeats, 0, 1'b0, vecs[i].bresp);
    end
    s_awvalid = '0;

    // All ports requesting continuously after reset: strict 0,1,2 rotation.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      awid_p[p] = 4'(p + 7); addr_p[p] = 32'h1000 * (p + 1); len_p[p] = 8'd0;
    end
    for (int i = 0; i < 6; i++)
      txn(3'b111, order[i], {order[i], awid_p[order[i]]}, 1, 0, 1'b0, 2'b00);

    // Downstream AW stalled for 5 cycles with the other ports still requesting.
    g = rr_pick(3'b111, model_last);
    txn(3'b111, g, {g, awid_p[g]}, 2, 5, 1'b0, 2'b01);
    s_awvalid = '0;

    // Port 2 presents W early while port 0 owns the channel.
    do_reset();
    s_wvalid[2] = 1'b1; s_wlast[2] = 1'b1; wdata_p[2] = 32'hCAFE_F00D;
    txn(3'b101, 2'd0, {2'd0, awid_p[0]}, 2, 0, 1'b0, 2'b00);
    check("early_w_kept", {s_wvalid[2], wdata_p[2]}, {1'b1, 32'hCAFE_F00D});
    txn(3'b100, 2'd2, {2'd2, awid_p[2]}, 1, 0, 1'b0, 2'b00);
    s_awvalid = '0;

    // Toggling m_wready over a 4-beat burst.
    txn(3'b010, 2'd1, {2'd1, awid_p[1]}, 4, 0, 1'b1, 2'b10);
    s_awvalid = '0;

    // Reset while in W: transaction abandoned, port 0 wins first after reset.
    do_reset();
    s_awvalid = 3'b010;
    #1;
    for (int t = 0; t < 8 && s_awready == 3'b000; t++) cyc();
    check("rst_w_grant1", s_awready, 3'b010);
    cyc();
    s_awvalid = '0; m_awready = 1'b1;
    cyc();
    m_awready = 1'b0; s_wvalid = 3'b010; wdata_p[1] = 32'h5555_AAAA; m_wready = 1'b0;
    #1;
    check("rst_w_in_w", m_wvalid, 1'b1);
    aresetn = 1'b0; s_awvalid = 3'b111;
    #1;
    check("rst_w_awready_gated", s_awready, 3'b000);
    cyc();
    check_all_zero("rst_w_after");
    aresetn = 1'b1;
    #1;
    check("rst_w_first_cycle", {s_awready, m_wvalid, s_wready}, '0);
    cyc();
    check("rst_w_first_grant", s_awready, 3'b001);
    s_wvalid = '0;
    model_last = 2'd2;
    txn(3'b001, 2'd0, {2'd0, awid_p[0]}, 1, 0, 1'b0, 2'b00);
    s_awvalid = '0;

    // Randomized traffic against the round-robin model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 3; p++) begin
        awid_p[p] = 4'($urandom); addr_p[p] = $urandom; len_p[p] = 8'($urandom);
      end
      mask = 3'($urandom_range(1, 7));
      g = rr_pick(mask, model_last);
      txn(mask, g, {g, awid_p[g]}, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
          1'($urandom), 2'($urandom));
    end
    s_awvalid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
